prefetch_queue: RTL and testbench

Prefetch queue sitting directly downstream of the instruction-cache read formatter. Each cycle it accepts one 136-bit prefetch line, either a full cache-line slice or a partial burst word, consisting of two 68-bit entries {length[3:0], bytes[63:0]}. It stores the non-empty entries in order and presents them one at a time to the decode stage through an accept handshake. It also reports occupancy back to the fetch side for throttling and supports a single-cycle flush on control-flow change.

---
 rtl/prefetch_queue_pkg.sv | 21 ++
 rtl/prefetch_queue_bank.sv | 27 ++
 rtl/prefetch_queue.sv | 161 ++++++++++++++++
 tb/tb_prefetch_queue.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prefetch_queue_pkg.sv
// Shared widths, entry field offsets and helpers for the prefetch queue.
package prefetch_queue_pkg;

    localparam int unsigned PREFETCH_ENTRY_W = 68;
    localparam int unsigned PREFETCH_LINE_W  = 136;
    localparam int unsigned PREFETCH_LEN_W   = 4;

    // Entry layout: {len, bytes}
    localparam int unsigned ENTRY_LEN_LSB   = 64;
    localparam int unsigned ENTRY_LEN_MSB   = ENTRY_LEN_LSB + PREFETCH_LEN_W - 1;
    localparam int unsigned ENTRY_BYTES_LSB = 0;
    localparam int unsigned ENTRY_BYTES_MSB = 63;

    typedef logic [PREFETCH_ENTRY_W-1:0] entry_t;

    // An entry carries data iff its length field is non-zero.
    function automatic logic entry_valid(input entry_t e);
        return e[ENTRY_LEN_MSB:ENTRY_LEN_LSB] != '0;
    endfunction

endpackage

// File: rtl/prefetch_queue_bank.sv
// One storage bank: single write port, single asynchronous read port.
// Contents are not reset; occupancy tracking lives in the parent.
module prefetch_queue_bank
    import prefetch_queue_pkg::*;
#(
    parameter int unsigned SLOTS = 8
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(SLOTS)-1:0] waddr_i,
    input  entry_t                   wdata_i,
    input  logic [$clog2(SLOTS)-1:0] raddr_i,
    output entry_t                   rdata_o
);

    entry_t mem_q [SLOTS];

    // Storage write
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/prefetch_queue.sv
// Prefetch queue: accepts up to two entries per cycle from the cache read
// formatter and hands them to decode one at a time.
// Optional feature macro: PREFETCH_QUEUE_BYPASS_EN (zero-latency write-to-read
// bypass when the queue is empty).
module prefetch_queue
    import prefetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        wr_do,
    input  logic [PREFETCH_LINE_W-1:0]  wr_line,
    output logic                        wr_ready,
    output logic [$clog2(DEPTH):0]      used,
    output logic                        rd_empty,
    output logic [PREFETCH_ENTRY_W-1:0] rd_data,
    input  logic                        rd_accept,
    output logic                        overflow
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned BAW = AW - 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] used_q, used_d;
    logic          wr_ready_q, wr_ready_d;
    logic          overflow_q, overflow_d;
    entry_t        head_q, head_d;

    entry_t        lo_e, hi_e, e0, e1;
    logic          lo_v, hi_v;
    logic [1:0]    n_wr;
    logic          wr_acc, we0, we1, pop, byp;
    logic [AW-1:0] slot0, slot1;

    logic          even_we, odd_we;
    logic [BAW-1:0] even_waddr, odd_waddr;
    entry_t        even_wdata, odd_wdata;
    entry_t        even_rdata, odd_rdata, mem_head;

    assign lo_e = wr_line[PREFETCH_ENTRY_W-1:0];
    assign hi_e = wr_line[PREFETCH_LINE_W-1:PREFETCH_ENTRY_W];
    assign lo_v = entry_valid(lo_e);
    assign hi_v = entry_valid(hi_e);

    // Compact valid entries: e0 is the first to enqueue, e1 only exists when both are valid.
    assign e0   = lo_v ? lo_e : hi_e;
    assign e1   = hi_e;
    assign n_wr = {1'b0, lo_v} + {1'b0, hi_v};

    assign wr_acc = wr_do & wr_ready_q & ~flush;
    assign we0    = wr_acc & (n_wr != 2'd0);
    assign we1    = wr_acc & (n_wr == 2'd2);
    assign slot0  = wr_ptr_q;
    assign slot1  = wr_ptr_q + AW'(1);

`ifdef PREFETCH_QUEUE_BYPASS_EN
    assign byp = (used_q == '0) & we0;
`else
    assign byp = 1'b0;
`endif

    assign rd_empty = (used_q == '0) & ~byp;
    assign rd_data  = byp ? e0 : head_q;
    // A bypassed entry is still written; popping it just moves rd_ptr past it.
    assign pop      = rd_accept & ~rd_empty;

    // Steer e0/e1 into the even/odd banks according to the write pointer LSB
    always_comb begin
        if (!wr_ptr_q[0]) begin
            even_we    = we0;
            even_waddr = slot0[AW-1:1];
            even_wdata = e0;
            odd_we     = we1;
            odd_waddr  = slot1[AW-1:1];
            odd_wdata  = e1;
        end else begin
            odd_we     = we0;
            odd_waddr  = slot0[AW-1:1];
            odd_wdata  = e0;
            even_we    = we1;
            even_waddr = slot1[AW-1:1];
            even_wdata = e1;
        end
    end

    prefetch_queue_bank #(
        .SLOTS(DEPTH / 2)
    ) u_bank_even (
        .clk     (clk),
        .we_i    (even_we),
        .waddr_i (even_waddr),
        .wdata_i (even_wdata),
        .raddr_i (rd_ptr_d[AW-1:1]),
        .rdata_o (even_rdata)
    );

    prefetch_queue_bank #(
        .SLOTS(DEPTH / 2)
    ) u_bank_odd (
        .clk     (clk),
        .we_i    (odd_we),
        .waddr_i (odd_waddr),
        .wdata_i (odd_wdata),
        .raddr_i (rd_ptr_d[AW-1:1]),
        .rdata_o (odd_rdata)
    );

    assign mem_head = rd_ptr_d[0] ? odd_rdata : even_rdata;

    // Next-state: pointers, count, ready, sticky overflow and registered head
    always_comb begin
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        wr_ptr_d   = wr_ptr_q + AW'(wr_acc ? n_wr : 2'd0);
        used_d     = used_q + CW'(wr_acc ? n_wr : 2'd0) - CW'(pop);
        overflow_d = overflow_q | (wr_do & ~wr_ready_q);
        // Head slot may be written this very cycle; forward it past the bank.
        head_d     = mem_head;
        if (we0 && (rd_ptr_d == slot0)) begin
            head_d = e0;
        end else if (we1 && (rd_ptr_d == slot1)) begin
            head_d = e1;
        end
        if (flush) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            used_d     = '0;
            overflow_d = 1'b0;
            head_d     = '0;
        end
        wr_ready_d = (used_d <= CW'(DEPTH - 2));
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            used_q     <= '0;
            wr_ready_q <= 1'b1;
            overflow_q <= 1'b0;
            head_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            used_q     <= used_d;
            wr_ready_q <= wr_ready_d;
            overflow_q <= overflow_d;
            head_q     <= head_d;
        end
    end

    assign used     = used_q;
    assign wr_ready = wr_ready_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_prefetch_queue.sv
// Self-checking bench for prefetch_queue (DEPTH=16).
module tb_prefetch_queue;

    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         wr_do;
    logic [135:0] wr_line;
    logic         wr_ready;
    logic [4:0]   used;
    logic         rd_empty;
    logic [67:0]  rd_data;
    logic         rd_accept;
    logic         overflow;

    int n_checks = 0;
    int n_err    = 0;

    prefetch_queue #(
        .DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .wr_do     (wr_do),
        .wr_line   (wr_line),
        .wr_ready  (wr_ready),
        .used      (used),
        .rd_empty  (rd_empty),
        .rd_data   (rd_data),
        .rd_accept (rd_accept),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic        wd;
        logic        acc;
        logic [3:0]  ll;
        logic [63:0] lb;
        logic [3:0]  hl;
        logic [63:0] hb;
        logic [4:0]  e_used;
        logic        e_empty;
        logic        e_ready;
        logic        e_ovf;
        logic        chk_data;
        logic [67:0] e_data;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic fl, wd, acc, input logic [3:0] ll, input logic [63:0] lb,
                       input logic [3:0] hl, input logic [63:0] hb, input logic [4:0] e_used,
                       input logic e_empty, e_ready, e_ovf, chk_data, input logic [67:0] e_data);
        vec_t v;
        v.fl = fl; v.wd = wd; v.acc = acc; v.ll = ll; v.lb = lb; v.hl = hl; v.hb = hb;
        v.e_used = e_used; v.e_empty = e_empty; v.e_ready = e_ready; v.e_ovf = e_ovf;
        v.chk_data = chk_data; v.e_data = e_data;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic fl, wd, acc, input logic [3:0] ll, input logic [63:0] lb,
                         input logic [3:0] hl, input logic [63:0] hb);
        @(negedge clk);
        flush     = fl;
        wr_do     = wd;
        rd_accept = acc;
        wr_line   = {hl, hb, ll, lb};
        @(posedge clk);
        #1;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            drive(vecs[i].fl, vecs[i].wd, vecs[i].acc, vecs[i].ll, vecs[i].lb,
                  vecs[i].hl, vecs[i].hb);
            chk($sformatf("v%0d used", i), 68'(used), 68'(vecs[i].e_used));
            chk($sformatf("v%0d rd_empty", i), 68'(rd_empty), 68'(vecs[i].e_empty));
            chk($sformatf("v%0d wr_ready", i), 68'(wr_ready), 68'(vecs[i].e_ready));
            chk($sformatf("v%0d overflow", i), 68'(overflow), 68'(vecs[i].e_ovf));
            if (vecs[i].chk_data) begin
                chk($sformatf("v%0d rd_data", i), rd_data, vecs[i].e_data);
            end
        end
    endtask

    logic [67:0] mq[$];
    logic [67:0] drain_exp[$];
    int          split;

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        wr_do     = 1'b0;
        rd_accept = 1'b0;
        wr_line   = '0;

        // Stimulus table, part 1: basic ordering, lo-skip, fill, overflow
        add(0, 1, 0, 4'd8, 64'h0706050403020100, 4'd3, 64'h0A0908,
            5'd2, 0, 1, 0, 1, {4'd8, 64'h0706050403020100});
        add(0, 0, 1, 0, 0, 0, 0, 5'd1, 0, 1, 0, 1, {4'd3, 64'h0A0908});
        add(0, 0, 1, 0, 0, 0, 0, 5'd0, 1, 1, 0, 0, '0);
        add(0, 1, 0, 4'd0, 64'hDEAD, 4'd5, 64'h55, 5'd1, 0, 1, 0, 1, {4'd5, 64'h55});
        add(0, 0, 1, 0, 0, 0, 0, 5'd0, 1, 1, 0, 0, '0);
        for (int i = 0; i < 7; i++) begin
            add(0, 1, 0, 4'd1, 64'h100 + 64'(2 * i), 4'd2, 64'h101 + 64'(2 * i),
                5'(2 * i + 2), 0, 1, 0, 1, {4'd1, 64'h100});
        end
        add(0, 1, 0, 4'd4, 64'hAA, 4'd0, 64'h0, 5'd15, 0, 0, 0, 1, {4'd1, 64'h100});
        add(0, 1, 0, 4'd8, 64'hBB, 4'd8, 64'hCC, 5'd15, 0, 0, 1, 1, {4'd1, 64'h100});
        add(0, 0, 1, 0, 0, 0, 0, 5'd14, 0, 1, 1, 1, {4'd2, 64'h101});
        split = vecs.size();
        // Part 2: write+accept at used=4, flush with write and accept at used=7
        add(0, 1, 0, 4'd1, 64'h200, 4'd1, 64'h201, 5'd2, 0, 1, 1, 1, {4'd1, 64'h200});
        add(0, 1, 0, 4'd1, 64'h202, 4'd1, 64'h203, 5'd4, 0, 1, 1, 1, {4'd1, 64'h200});
        add(0, 1, 1, 4'd1, 64'h204, 4'd1, 64'h205, 5'd5, 0, 1, 1, 1, {4'd1, 64'h201});
        add(0, 1, 0, 4'd1, 64'h206, 4'd1, 64'h207, 5'd7, 0, 1, 1, 1, {4'd1, 64'h201});
        add(1, 1, 1, 4'd8, 64'hEE, 4'd8, 64'hEF, 5'd0, 1, 1, 0, 0, '0);
        add(0, 1, 0, 4'd2, 64'h300, 4'd0, 64'h0, 5'd1, 0, 1, 0, 1, {4'd2, 64'h300});
        add(0, 0, 1, 0, 0, 0, 0, 5'd0, 1, 1, 0, 0, '0);

        // Entries left behind {2,0x101} after the overflow/accept step
        for (int k = 1; k < 7; k++) begin
            drain_exp.push_back({4'd1, 64'h100 + 64'(2 * k)});
            drain_exp.push_back({4'd2, 64'h101 + 64'(2 * k)});
        end
        drain_exp.push_back({4'd4, 64'hAA});

        // Reset state, checked asynchronously and after an idle edge
        #1;
        chk("async reset used", 68'(used), 68'd0);
        chk("async reset rd_empty", 68'(rd_empty), 68'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle used", 68'(used), 68'd0);
        chk("idle rd_empty", 68'(rd_empty), 68'd1);
        chk("idle wr_ready", 68'(wr_ready), 68'd1);
        chk("idle rd_data", rd_data, 68'd0);
        chk("idle overflow", 68'(overflow), 68'd0);

        run_vecs(0, split);

        // Drain the full queue; stored contents must survive the rejected write
        for (int j = 0; j < 13; j++) begin
            drive(0, 0, 1, 0, 0, 0, 0);
            chk($sformatf("drain%0d used", j), 68'(used), 68'(13 - j));
            chk($sformatf("drain%0d rd_data", j), rd_data, drain_exp[j]);
        end
        drive(0, 0, 1, 0, 0, 0, 0);
        chk("drain end used", 68'(used), 68'd0);
        chk("drain end rd_empty", 68'(rd_empty), 68'd1);

        run_vecs(split, vecs.size());

        // Randomised traffic against a queue model, many pointer laps
        for (int c = 0; c < 300; c++) begin
            logic        wd, acc, rdy;
            logic [3:0]  ll, hl;
            logic [63:0] lb, hb;
            int          sz0;
            sz0 = mq.size();
            rdy = (sz0 <= DEPTH - 2);
            wd  = rdy && ($urandom_range(0, 3) != 0);
            ll  = 4'($urandom_range(0, 8));
            hl  = 4'($urandom_range(0, 8));
            lb  = {$urandom, $urandom};
            hb  = {$urandom, $urandom};
            acc = 1'($urandom_range(0, 1));
            if (wd) begin
                if (ll != 0) mq.push_back({ll, lb});
                if (hl != 0) mq.push_back({hl, hb});
            end
`ifdef PREFETCH_QUEUE_BYPASS_EN
            if (acc && mq.size() > 0) void'(mq.pop_front());
`else
            if (acc && sz0 > 0) void'(mq.pop_front());
`endif
            drive(0, wd, acc, ll, lb, hl, hb);
            chk($sformatf("rnd%0d used", c), 68'(used), 68'(mq.size()));
            chk($sformatf("rnd%0d rd_empty", c), 68'(rd_empty), 68'(mq.size() == 0));
            chk($sformatf("rnd%0d wr_ready", c), 68'(wr_ready), 68'(mq.size() <= DEPTH - 2));
            if (mq.size() > 0) begin
                chk($sformatf("rnd%0d rd_data", c), rd_data, mq[0]);
            end
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("rnd flush used", 68'(used), 68'd0);

        // Empty-queue write: same-cycle visibility only with bypass
        @(negedge clk);
        flush     = 1'b0;
        wr_do     = 1'b1;
        rd_accept = 1'b0;
        wr_line   = {4'd0, 64'h0, 4'd6, 64'h66};
        #1;
`ifdef PREFETCH_QUEUE_BYPASS_EN
        chk("bypass rd_empty", 68'(rd_empty), 68'd0);
        chk("bypass rd_data", rd_data, {4'd6, 64'h66});
        rd_accept = 1'b1;
        @(posedge clk);
        #1;
        chk("bypass consumed used", 68'(used), 68'd0);
        chk("bypass consumed rd_empty", 68'(rd_empty), 68'd1);
        drive(0, 1, 1, 4'd6, 64'h61, 4'd7, 64'h71);
        chk("bypass rest used", 68'(used), 68'd1);
        chk("bypass rest rd_data", rd_data, {4'd7, 64'h71});
`else
        chk("no-bypass rd_empty", 68'(rd_empty), 68'd1);
        @(posedge clk);
        #1;
        chk("no-bypass latency rd_empty", 68'(rd_empty), 68'd0);
        chk("no-bypass latency rd_data", rd_data, {4'd6, 64'h66});
`endif
        drive(0, 1, 0, 4'd1, 64'h11, 4'd1, 64'h12);

        // Asynchronous reset mid-operation, then write on the first edge after release
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst used", 68'(used), 68'd0);
        chk("midrst rd_empty", 68'(rd_empty), 68'd1);
        chk("midrst rd_data", rd_data, 68'd0);
        chk("midrst wr_ready", 68'(wr_ready), 68'd1);
        @(negedge clk);
        rst_n     = 1'b1;
        wr_do     = 1'b1;
        rd_accept = 1'b0;
        wr_line   = {4'd0, 64'h0, 4'd3, 64'h77};
        @(posedge clk);
        #1;
        chk("postrst used", 68'(used), 68'd1);
        chk("postrst rd_data", rd_data, {4'd3, 64'h77});
        @(negedge clk);
        wr_do = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
